// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Accepts one ALU command at a time, drives an external combinational ALU and
// returns the result through a valid/ready handshake. ADD/SUB/SLL/AND (and the
// illegal opcodes 5-7) take a single ALU pass. MUL is built from 16 add/shift
// iterations on the same ALU, so it always takes exactly 32 ALU cycles.
//
// Ports
//   clk, reset               : rising-edge clock, asynchronous active-high reset
//   Cmd_valid/Cmd_ready      : command handshake (ready only while idle)
//   Cmd_op, Cmd_A, Cmd_B     : opcode (0 ADD,1 SUB,2 SLL,3 AND,4 MUL) and operands
//   Res_valid/Res_ready      : result handshake
//   Res_data, Res_zero       : registered result and its zero flag
//   ALU_InA, ALU_InB, ALU_cont : drive to the external ALU (1111 = idle)
//   ALU_output, ALU_zero     : combinational ALU response
// -----------------------------------------------------------------------------
module alu_op_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        Cmd_valid,
  output logic        Cmd_ready,
  input  logic [2:0]  Cmd_op,
  input  logic [15:0] Cmd_A,
  input  logic [15:0] Cmd_B,
  output logic        Res_valid,
  input  logic        Res_ready,
  output logic [15:0] Res_data,
  output logic        Res_zero,
  output logic [15:0] ALU_InA,
  output logic [15:0] ALU_InB,
  output logic [3:0]  ALU_cont,
  input  logic [15:0] ALU_output,
  input  logic        ALU_zero
);

  localparam int DATA_W = 16;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_IDLE = 4'b1111;
  localparam logic [2:0] OP_MUL   = 3'd4;

  typedef enum logic [2:0] {IDLE, EXEC, MUL_ADD, MUL_SHL, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  // M/Q hold A/B for single-pass ops too, so no separate operand registers.
  logic [DATA_W-1:0]   p_q, p_d;
  logic [DATA_W-1:0]   m_q, m_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_zero_q, res_zero_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      p_q        <= '0;
      m_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      p_q        <= p_d;
      m_q        <= m_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_zero_q <= res_zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    p_d        = p_q;
    m_d        = m_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_zero_d = res_zero_q;
    ALU_cont   = ALU_IDLE;
    ALU_InA    = '0;
    ALU_InB    = '0;

    case (state_q)
      IDLE: begin
        if (Cmd_valid) begin
          op_d    = Cmd_op;
          m_d     = Cmd_A;
          q_d     = Cmd_B;
          p_d     = '0;
          cnt_d   = '0;
          state_d = (Cmd_op == OP_MUL) ? MUL_ADD : EXEC;
        end
      end
      EXEC: begin
        ALU_InA    = m_q;
        ALU_InB    = q_q;
        // Opcodes 5-7 all have bit 2 set; they run the idle function and yield 0.
        ALU_cont   = op_q[2] ? ALU_IDLE : {1'b0, op_q};
        res_data_d = ALU_output;
        res_zero_d = ALU_zero;
        state_d    = DONE;
      end
      MUL_ADD: begin
        ALU_cont = ALU_ADD;
        ALU_InA  = p_q;
        ALU_InB  = q_q[0] ? m_q : '0;
        p_d      = ALU_output;
        state_d  = MUL_SHL;
      end
      MUL_SHL: begin
        ALU_cont = ALU_SLL;
        ALU_InA  = 16'd1;
        ALU_InB  = m_q;
        m_d      = ALU_output;
        q_d      = q_q >> 1;
        cnt_d    = cnt_q + 4'd1;
        // P already holds the final sum after the 16th add step.
        if (cnt_q == 4'd15) begin
          res_data_d = p_q;
          res_zero_d = (p_q == '0);
          state_d    = DONE;
        end else begin
          state_d    = MUL_ADD;
        end
      end
      DONE: begin
        if (Res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Cmd_ready = (state_q == IDLE);
  assign Res_valid = (state_q == DONE);
  assign Res_data  = res_data_q;
  assign Res_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic        clk;
  logic        reset;
  logic        Cmd_valid;
  logic        Cmd_ready;
  logic [2:0]  Cmd_op;
  logic [15:0] Cmd_A;
  logic [15:0] Cmd_B;
  logic        Res_valid;
  logic        Res_ready;
  logic [15:0] Res_data;
  logic        Res_zero;
  logic [15:0] ALU_InA;
  logic [15:0] ALU_InB;
  logic [3:0]  ALU_cont;
  logic [15:0] ALU_output;
  logic        ALU_zero;

  int total = 0;
  int bad   = 0;
  logic [16:0] sb[$];

  alu_op_sequencer dut (
    .clk(clk), .reset(reset),
    .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready), .Cmd_op(Cmd_op),
    .Cmd_A(Cmd_A), .Cmd_B(Cmd_B),
    .Res_valid(Res_valid), .Res_ready(Res_ready),
    .Res_data(Res_data), .Res_zero(Res_zero),
    .ALU_InA(ALU_InA), .ALU_InB(ALU_InB), .ALU_cont(ALU_cont),
    .ALU_output(ALU_output), .ALU_zero(ALU_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU
  always_comb begin
    ALU_output = 16'h0000;
    case (ALU_cont)
      4'b0000: ALU_output = ALU_InA + ALU_InB;
      4'b0001: ALU_output = ALU_InA - ALU_InB;
      4'b0010: ALU_output = ALU_InB << ALU_InA[3:0];
      4'b0011: ALU_output = ALU_InA & ALU_InB;
      default: ALU_output = 16'h0000;
    endcase
  end
  assign ALU_zero = (ALU_output == 16'h0000);

  // Expected {zero, data} for a command
  function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = b << a[3:0];
      3'd3: r = a & b;
      3'd4: r = a * b;
      default: r = 16'h0000;
    endcase
    return {(r == 16'h0000), r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle.
  task automatic run_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int exp_lat, input int hold, input string tag);
    logic [16:0] e;
    logic [15:0] d0;
    logic        z0;
    int          lat;
    Cmd_op = op; Cmd_A = a; Cmd_B = b; Cmd_valid = 1'b1;
    chk($sformatf("%s.cmd_ready", tag), Cmd_ready, 1);
    sb.push_back(model(op, a, b));
    @(posedge clk);
    @(negedge clk);
    Cmd_valid = 1'b0;
    Cmd_op = 3'($urandom); Cmd_A = 16'($urandom); Cmd_B = 16'($urandom);
    if (op > 3'd4)       chk($sformatf("%s.alu_cont", tag), ALU_cont, 4'hF);
    else if (op < 3'd4)  chk($sformatf("%s.alu_cont", tag), ALU_cont, {1'b0, op});
    else                 chk($sformatf("%s.alu_cont", tag), ALU_cont, 4'h0);
    lat = 0;
    while (!Res_valid && lat < 100) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk($sformatf("%s.latency", tag), lat, exp_lat);
    d0 = Res_data; z0 = Res_zero;
    for (int i = 0; i < hold; i++) begin
      Cmd_valid = 1'b1; Cmd_op = 3'd0; Cmd_A = 16'h0001; Cmd_B = 16'h0001;
      @(posedge clk); @(negedge clk);
      chk($sformatf("%s.hold_valid%0d", tag, i), Res_valid, 1);
      chk($sformatf("%s.hold_data%0d", tag, i), Res_data, d0);
      chk($sformatf("%s.hold_zero%0d", tag, i), Res_zero, z0);
      chk($sformatf("%s.hold_ready%0d", tag, i), Cmd_ready, 0);
    end
    Cmd_valid = 1'b0;
    e = sb.pop_front();
    chk($sformatf("%s.data", tag), Res_data, e[15:0]);
    chk($sformatf("%s.zero", tag), Res_zero, e[16]);
    Res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    Res_ready = 1'b0;
    chk($sformatf("%s.valid_drop", tag), Res_valid, 0);
    chk($sformatf("%s.back_idle", tag), Cmd_ready, 1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk($sformatf("%s.cmd_ready", tag), Cmd_ready, 1);
    chk($sformatf("%s.res_valid", tag), Res_valid, 0);
    chk($sformatf("%s.res_data", tag), Res_data, 16'h0000);
    chk($sformatf("%s.res_zero", tag), Res_zero, 0);
    chk($sformatf("%s.alu_cont", tag), ALU_cont, 4'hF);
    chk($sformatf("%s.alu_ina", tag), ALU_InA, 16'h0000);
    chk($sformatf("%s.alu_inb", tag), ALU_InB, 16'h0000);
  endtask

  initial begin
    reset = 1'b0; Cmd_valid = 1'b0; Cmd_op = 3'd0; Cmd_A = 16'h0; Cmd_B = 16'h0; Res_ready = 1'b0;
    #1 reset = 1'b1;
    #2 chk_reset_state("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_cmd(3'd0, 16'h7FFF, 16'h0001, 1,  0, "add_ovf");
    run_cmd(3'd1, 16'h1234, 16'h1234, 1,  0, "sub_zero");
    run_cmd(3'd2, 16'h0004, 16'h00F1, 1,  0, "sll4");
    run_cmd(3'd2, 16'h0013, 16'h0001, 1,  0, "sll_hibits");
    run_cmd(3'd3, 16'hF0F0, 16'h3C3C, 1,  0, "and");
    run_cmd(3'd0, 16'hFFFF, 16'h0001, 1,  0, "add_wrap");
    run_cmd(3'd4, 16'h0003, 16'h0005, 32, 0, "mul_3x5");
    run_cmd(3'd4, 16'h0100, 16'h0100, 32, 0, "mul_wrap0");
    run_cmd(3'd4, 16'hFFFF, 16'hFFFF, 32, 0, "mul_ffff");
    run_cmd(3'd6, 16'hFFFF, 16'hFFFF, 1,  0, "illegal6");
    run_cmd(3'd0, 16'h1111, 16'h2222, 1,  5, "add_hold");
    run_cmd(3'd4, 16'h1234, 16'h0003, 32, 3, "mul_hold");

    // Abort a MUL in iteration 7 with an asynchronous reset.
    Cmd_op = 3'd4; Cmd_A = 16'h0003; Cmd_B = 16'h0005; Cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    Cmd_valid = 1'b0;
    repeat (14) begin @(posedge clk); @(negedge clk); end
    chk("abort.in_mul", ALU_cont, 4'h0);
    #2 reset = 1'b1;
    #1 chk_reset_state("abort");
    @(posedge clk); @(negedge clk);
    chk("abort.no_result", Res_valid, 0);
    reset = 1'b0;
    run_cmd(3'd0, 16'h0100, 16'h0023, 1, 0, "add_after_abort");
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("final.no_stray_valid", Res_valid, 0);
    chk("final.sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
